// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, ID branch/jump flushes, multi-cycle MDU hold
// and debug halt/single-step. Define HAZARD_PERF_CNT_EN to add stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        ex_mdu_start,
  input  logic        dbg_halt_req,
  input  logic        dbg_step,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        ex_hold,
  output logic        halted,
  output logic [1:0]  fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MDU_BUSY = 2'd1,
    S_HALT     = 2'd2,
    S_STEP     = 2'd3
  } state_t;

  localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       step_used_q, step_used_d;
  logic       load_use;
  logic       run_like;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign run_like = (state_q == S_RUN) || (state_q == S_STEP);
  assign fsm_state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= 4'd0;
      step_used_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_used_q <= step_used_d;
    end
  end

  // Next-state logic. step_used blocks a held dbg_step from stepping twice;
  // it clears only once dbg_step has been seen low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_used_d = step_used_q & dbg_step;
    case (state_q)
      S_RUN: begin
        if (ex_mdu_start) begin
          state_d = S_MDU_BUSY;
          cnt_d   = MDU_LOAD;
        end else if (dbg_halt_req && !load_use) begin
          state_d = S_HALT;
        end
      end
      S_MDU_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = dbg_halt_req ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        if (!dbg_halt_req) begin
          state_d = S_RUN;
        end else if (dbg_step && !step_used_q) begin
          state_d     = S_STEP;
          step_used_d = 1'b1;
        end
      end
      S_STEP: begin
        if (ex_mdu_start) begin
          state_d = S_MDU_BUSY;
          cnt_d   = MDU_LOAD;
        end else if (dbg_halt_req) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs: RUN defaults while reset is held, otherwise decoded from state and inputs
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    ex_hold     = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      if (run_like) begin
        if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          ifid_flush = id_branch_taken | id_jump;
        end
      end else if (state_q == S_MDU_BUSY) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ex_hold    = 1'b1;
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (state_q != S_HALT)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_LAT, default 4, meaning total EX-stage cycles of a multi-cycle multiply/divide op (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 each, the source register numbers of the instruction in ID.
REQ-005 The block SHALL have port id_uses_rt, input, 1, high when the ID instruction reads rt.
REQ-006 The block SHALL have ports ex_mem_read (input, 1, EX instruction is a load) and ex_rt (input, 5, load destination).
REQ-007 The block SHALL have ports id_branch_taken and id_jump, input, 1 each, control transfer resolved in ID.
REQ-008 The block SHALL have port ex_mdu_start, input, 1, a multi-cycle op entering EX this cycle.
REQ-009 The block SHALL have ports dbg_halt_req (input, 1, level) and dbg_step (input, 1, single-cycle pulse).
REQ-010 The block SHALL have outputs pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold and halted, 1 bit each.

Function
REQ-011 The block SHALL implement the FSM states RUN, MDU_BUSY, HALT and STEP; outputs SHALL be combinational from the state and the current inputs.
REQ-012 RUN defaults SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, ex_hold=0, halted=0.
REQ-013 Load-use is defined as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)); in RUN it SHALL force pc_write=0, ifid_write=0, idex_bubble=1 for that cycle only, with no state change.
REQ-014 In RUN without load-use, id_branch_taken|id_jump SHALL assert ifid_flush; during a load-use stall, ifid_flush SHALL be 0, because the branch re-resolves next cycle.
REQ-015 In RUN, ex_mdu_start SHALL move the FSM to MDU_BUSY and load a 4-bit counter with MDU_LAT-1; ex_mdu_start SHALL take priority over load-use and halt entry.
REQ-016 MDU_BUSY SHALL drive pc_write=0, ifid_write=0, ex_hold=1, idex_bubble=0 and decrement the counter each cycle.
REQ-017 When the counter reaches 1, the FSM SHALL move to RUN, or to HALT if dbg_halt_req=1; the EX op therefore occupies exactly MDU_LAT cycles.
REQ-018 Branch, load-use and dbg_step inputs SHALL be ignored in MDU_BUSY.
REQ-019 In RUN with dbg_halt_req=1, no ex_mdu_start and no load-use, the FSM SHALL enter HALT at the next edge; a load-use stall SHALL complete before HALT is entered.
REQ-020 HALT SHALL drive pc_write=0, ifid_write=0, idex_bubble=1 and halted=1, so bubbles drain EX/MEM/WB while IF/ID stay frozen.
REQ-021 In HALT, dbg_halt_req=0 SHALL return the FSM to RUN at the next edge; otherwise dbg_step=1 SHALL move it to STEP.
REQ-022 STEP SHALL last exactly one cycle with RUN semantics, including load-use, flush and mdu_start per REQ-013 to REQ-015, and halted=0.
REQ-023 After STEP, the next state SHALL be MDU_BUSY if mdu_start fired, else HALT if dbg_halt_req=1, else RUN.
REQ-024 A dbg_step held high SHALL advance only one instruction per HALT-to-STEP transition.

Reset
REQ-025 rst_n=0 SHALL immediately force state RUN and counter 0, and clear the performance counters, regardless of the current state, including mid-MDU_BUSY and mid-HALT.
REQ-026 While rst_n=0, the outputs SHALL be the RUN defaults with ifid_flush=0.

Configuration
REQ-027 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-028 stall_cnt SHALL increment on each cycle with pc_write=0 outside HALT.
REQ-029 flush_cnt SHALL increment on each cycle with ifid_flush=1.
REQ-030 Both counters SHALL wrap modulo 2^32.
REQ-031 Without HAZARD_PERF_CNT_EN, the ports and counters SHALL be absent, with identical other behaviour.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rt=9, id_rs=9 -> exactly one cycle with pc_write=0, idex_bubble=1; with ex_rt=0 -> no stall.
REQ-033 Branch vs stall: id_branch_taken=1 together with load-use -> ifid_flush=0 that cycle; next cycle, without load-use -> ifid_flush=1.
REQ-034 MDU: ex_mdu_start pulse with MDU_LAT=4 -> ex_hold=1 for 3 following cycles, pc_write=0 for those 3, then RUN defaults.
REQ-035 Halt/step: assert dbg_halt_req -> halted=1 next cycle; dbg_step pulse -> one cycle pc_write=1, then halted=1 again; deassert dbg_halt_req -> RUN next cycle.
REQ-036 Reset mid-MDU: rst_n low on the 2nd MDU_BUSY cycle -> outputs immediately the RUN defaults; after release, a new mdu_start gives the full MDU_LAT.
REQ-037 With HAZARD_PERF_CNT_EN: the REQ-034 sequence plus 2 flushes -> stall_cnt=3, flush_cnt=2.
